// File: rtl/matmul5_seq.sv
`default_nettype none
// ============================================================================
// Module   : matmul5_seq
// Purpose  : Sequencer for a 5x5 signed 8-bit matrix multiply. It walks the
//            (row, col) pairs in row-major order over a handshaked dot-product
//            MAC. Optional MAC timeout is enabled by the MATSEQ_TIMEOUT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module matmul5_seq #(
    parameter int MAC_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [199:0] mat_a,
    input  logic [199:0] mat_b,
    output logic [199:0] mat_c,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic         err,
    output logic [39:0]  mac_a,
    output logic [39:0]  mac_b,
    output logic         mac_en,
    input  logic [7:0]   mac_result,
    input  logic         mac_overflow,
    input  logic         mac_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    if (MAC_TIMEOUT < 1 || MAC_TIMEOUT > 15) begin : g_timeout_range
        $error("MAC_TIMEOUT must fit the 4-bit wait counter (1..15)");
    end

    logic [1:0]   r_state;
    logic [2:0]   r_i;
    logic [2:0]   r_j;
    logic [199:0] r_a;
    logic [199:0] r_b;
    logic [4:0]   w_idx;
    logic         w_timeout;

    assign w_idx = {r_i, 2'b00} + {2'b00, r_i} + {2'b00, r_j};

`ifdef MATSEQ_TIMEOUT_EN
    logic [3:0] r_wait;
    logic       r_err;

    assign w_timeout = (r_state == S_ISSUE) && !mac_done && (r_wait == 4'(MAC_TIMEOUT));
    assign err       = r_err;

    // The wait counter restarts on every entry into ISSUE (from IDLE or GAP).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= 4'd0;
            r_err  <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_wait <= 4'd0;
            r_err  <= 1'b0;
        end else if (r_state == S_GAP) begin
            r_wait <= 4'd0;
        end else if (r_state == S_ISSUE && !mac_done) begin
            if (w_timeout) begin
                r_err <= 1'b1;
            end else begin
                r_wait <= r_wait + 4'd1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_FINISH);
    assign mac_en = (r_state == S_ISSUE) && !w_timeout;

    // Operand muxes: mac_a byte k = A[i][k], mac_b byte k = B[k][j].
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        for (int k = 0; k < 5; k++) begin
            for (int r = 0; r < 5; r++) begin
                if (r_i == 3'(r)) mac_a[8*k +: 8] = r_a[8*(5*r+k) +: 8];
                if (r_j == 3'(r)) mac_b[8*k +: 8] = r_b[8*(5*k+r) +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= 3'd0;
            r_j     <= 3'd0;
            r_a     <= '0;
            r_b     <= '0;
            mat_c   <= '0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= mat_a;
                        r_b     <= mat_b;
                        mat_c   <= '0;
                        ovf     <= 1'b0;
                        r_i     <= 3'd0;
                        r_j     <= 3'd0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mac_done) begin
                        for (int n = 0; n < 25; n++) begin
                            if (w_idx == 5'(n)) mat_c[8*n +: 8] <= mac_result;
                        end
                        ovf     <= ovf | mac_overflow;
                        r_state <= S_GAP;
                    end else if (w_timeout) begin
                        r_state <= S_FINISH;
                    end
                end
                S_GAP: begin
                    if (r_j == 3'd4) begin
                        r_j <= 3'd0;
                        if (r_i == 3'd4) begin
                            r_i     <= 3'd0;
                            r_state <= S_FINISH;
                        end else begin
                            r_i     <= r_i + 3'd1;
                            r_state <= S_ISSUE;
                        end
                    end else begin
                        r_j     <= r_j + 3'd1;
                        r_state <= S_ISSUE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matmul5_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul5_seq
// Purpose  : Directed self-checking bench for matmul5_seq with a 6-cycle MAC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul5_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [199:0] mat_a = '0;
    logic [199:0] mat_b = '0;
    logic [199:0] mat_c;
    logic         busy, done, ovf, err;
    logic [39:0]  mac_a, mac_b;
    logic         mac_en;
    logic [7:0]   mac_result;
    logic         mac_overflow;
    logic         mac_done;

    int total = 0;
    int bad   = 0;

    // MAC model controls and run observations
    logic         nodone = 1'b0;
    logic         inject = 1'b0;
    int           mcnt = 0;
    int           mdn  = 0;
    logic         chk_a = 1'b0, chk_b = 1'b0;
    logic [39:0]  exp_a = '0, exp_b = '0;
    logic [199:0] poke_a = '0;
    logic [199:0] exp_c;
    int           en_cnt, bad_a, bad_b, ovf_cyc, dcyc;
    logic         ovf1;

    matmul5_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mat_a        (mat_a),
        .mat_b        (mat_b),
        .mat_c        (mat_c),
        .busy         (busy),
        .done         (done),
        .ovf          (ovf),
        .err          (err),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_en       (mac_en),
        .mac_result   (mac_result),
        .mac_overflow (mac_overflow),
        .mac_done     (mac_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dot(input logic [39:0] a, input logic [39:0] b);
        int s = 0;
        for (int k = 0; k < 5; k++) s += int'($signed(a[8*k +: 8])) * int'($signed(b[8*k +: 8]));
        return s[7:0];
    endfunction

    // MAC model: done on the 7th enabled cycle (L = 6); element 13 is (2,3).
    always @(posedge clk) begin
        mcnt <= mac_en ? mcnt + 1 : 0;
        if (start) mdn <= 0;
        else if (mac_done) mdn <= mdn + 1;
    end
    assign mac_done     = mac_en && (mcnt == 6) && !nodone;
    assign mac_result   = dot(mac_a, mac_b);
    assign mac_overflow = inject && mac_done && (mdn == 13);

    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Cycle 0 is the cycle in which start is sampled.
    task automatic run(input int poke, input int rstc, output int dc, output logic o1);
        en_cnt = 0; bad_a = 0; bad_b = 0; ovf_cyc = -1; dc = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        o1 = ovf;
        chk("busy_c1", {199'd0, busy}, 200'd1);
        for (int c = 1; c <= 3000; c++) begin
            if (mac_en) begin
                en_cnt++;
                if (chk_a && mac_a !== exp_a) bad_a++;
                if (chk_b && mac_b !== exp_b) bad_b++;
            end
            if (ovf && ovf_cyc < 0) ovf_cyc = c;
            if (done) begin dc = c; break; end
            start = (c == poke);
            if (c == poke) mat_a = poke_a;
            if (c == rstc) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (dc >= 0) begin
            @(negedge clk);
            chk("idle_after_done", {198'd0, done, busy}, 200'd0);
        end
    endtask

    task automatic set_identity();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                mat_a[8*(5*r+c) +: 8] = (r == c) ? 8'd1 : 8'd0;
                mat_b[8*(5*r+c) +: 8] = 8'(5*r + c);
            end
        exp_c = mat_b;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_mat_c"}, mat_c, 200'd0);
        chk({tag, "_flags"}, {195'd0, busy, done, ovf, err, mac_en}, 200'd0);
        chk({tag, "_mac_ab"}, {120'd0, mac_a, mac_b}, 200'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset("reset");

        // Identity x B gives B back
        set_identity();
        run(-1, -1, dcyc, ovf1);
        chk("id_done_cycle", 200'(dcyc), 200'd201);
        chk("id_mat_c", mat_c, exp_c);
        chk("id_ovf", {199'd0, ovf}, 200'd0);
        chk("id_issue_cycles", 200'(en_cnt), 200'd175);
`ifndef MATSEQ_TIMEOUT_EN
        chk("err_tied_low", {199'd0, err}, 200'd0);
`endif

        // All 2 x all 3: each element 5*6 = 30
        mat_a = {25{8'h02}}; mat_b = {25{8'h03}};
        chk_a = 1'b1; exp_a = 40'h0202020202;
        run(-1, -1, dcyc, ovf1);
        chk_a = 1'b0;
        chk("twos_mat_c", mat_c, {25{8'h1E}});
        chk("twos_mac_a", 200'(bad_a), 200'd0);
        chk("twos_ovf", {199'd0, ovf}, 200'd0);

        // All -1 x all 4: each element -20
        mat_a = {25{8'hFF}}; mat_b = {25{8'h04}};
        run(-1, -1, dcyc, ovf1);
        chk("neg_mat_c", mat_c, {25{8'hEC}});

        // B[k][j] = k exercises column ordering; each element -(0+1+2+3+4) = -10
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) mat_b[8*(5*r+c) +: 8] = 8'(r);
        chk_b = 1'b1; exp_b = 40'h0403020100;
        run(-1, -1, dcyc, ovf1);
        chk_b = 1'b0;
        chk("col_mac_b", 200'(bad_b), 200'd0);
        chk("col_mat_c", mat_c, {25{8'hF6}});

        // Overflow injected on element (2,3): done at cycle 111, ovf seen from 112
        inject = 1'b1;
        run(-1, -1, dcyc, ovf1);
        inject = 1'b0;
        chk("ovf_first_cycle", 200'(ovf_cyc), 200'd112);
        chk("ovf_sticky", {199'd0, ovf}, 200'd1);

        // A fresh start clears the sticky overflow
        mat_a = {25{8'h02}}; mat_b = {25{8'h03}};
        run(-1, -1, dcyc, ovf1);
        chk("ovf_cleared", {199'd0, ovf1}, 200'd0);
        chk("ovf_cleared_end", {199'd0, ovf}, 200'd0);

        // Start re-pulsed and mat_a changed mid-run: both ignored
        poke_a = {25{8'h01}};
        run(50, -1, dcyc, ovf1);
        chk("poke_done_cycle", 200'(dcyc), 200'd201);
        chk("poke_mat_c", mat_c, {25{8'h1E}});

        // Reset at cycle 100 returns everything to zero on the next cycle
        run(-1, 100, dcyc, ovf1);
        check_reset("midrun_rst");

        set_identity();
        run(-1, -1, dcyc, ovf1);
        chk("post_rst_done_cycle", 200'(dcyc), 200'd201);
        chk("post_rst_mat_c", mat_c, exp_c);

`ifdef MATSEQ_TIMEOUT_EN
        // MAC never completes: ISSUE cycles 1..15, done at 17
        nodone = 1'b1;
        run(-1, -1, dcyc, ovf1);
        nodone = 1'b0;
        chk("to_done_cycle", 200'(dcyc), 200'd17);
        chk("to_err", {199'd0, err}, 200'd1);
        chk("to_mat_c", mat_c, 200'd0);
        chk("to_issue_cycles", 200'(en_cnt), 200'd15);
        run(-1, -1, dcyc, ovf1);
        chk("to_err_cleared", {199'd0, err}, 200'd0);
        chk("to_recover_mat_c", mat_c, exp_c);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul5_seq.md
# matmul5_seq

Sequencer for 5x5 signed 8-bit matrix multiply C = A x B. Captures A and B on `start` and walks all 25 (row, column) pairs in row-major order. For each pair it presents row i of A and column j of B to the dot-product MAC, holds them with `mac_en` until `mac_done`, and stores the MAC result in C. It is the initiator side of the MAC handshake and sits between the HPS-facing register bank and the MAC.

## Interface
- `MAC_TIMEOUT`, default 15: maximum cycles to wait for `mac_done` per element. Used only when `MATSEQ_TIMEOUT_EN` is defined.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high. Clock `clk`.
- `start`, in, 1: begin a multiply. Sampled only in IDLE.
- `mat_a`, in, 200: matrix A. Element (r,c) occupies bits [8(5r+c)+7 : 8(5r+c)], two's complement.
- `mat_b`, in, 200: matrix B. Same packing as `mat_a`.
- `mat_c`, out, 200: result matrix C. Same packing.
- `busy`, out, 1: high from the cycle after `start` is accepted through the FINISH cycle.
- `done`, out, 1: one-cycle pulse in FINISH.
- `ovf`, out, 1: sticky OR of `mac_overflow` over the current run.
- `err`, out, 1: sticky timeout flag. Constant 0 without the macro.
- `mac_a`, out, 40: row vector. Byte k = A[i][k].
- `mac_b`, out, 40: column vector. Byte k = B[k][j].
- `mac_en`, out, 1: MAC enable.
- `mac_result`, in, 8: MAC dot-product result.
- `mac_overflow`, in, 1: MAC overflow flag.
- `mac_done`, in, 1: MAC completion, a single-cycle pulse.

## Operation
- Reset values: all outputs 0; state IDLE; i = j = 0. The captured A and B copies are cleared.
- **IDLE.** On `start`=1:
  - latch `mat_a` and `mat_b` into internal copies;
  - clear `mat_c`, `ovf` and `err`;
  - set i = j = 0;
  - go to ISSUE.
  - `start` in any other state is ignored. Later changes on `mat_a`/`mat_b` do not affect a run in progress.
- **ISSUE.**
  - `mac_a` and `mac_b` are driven from the latched copies for the current (i, j).
  - `mac_en`=1 and the operands are held stable every ISSUE cycle.
  - On `mac_done`=1: write `mac_result` into C[i][j], OR `mac_overflow` into `ovf`, go to GAP.
- **GAP.**
  - `mac_en`=0 for exactly one cycle, which lets the MAC self-clear.
  - Index advances j+1. When j wraps 4 -> 0, i advances.
  - After (i, j) = (4, 4), go to FINISH; otherwise return to ISSUE.
- **FINISH.** `done`=1 for one cycle, `busy` still 1, then go to IDLE.
- No arithmetic is done in this block. C elements are the raw 8-bit MAC results, wrapped as the MAC produces them.
- `mac_done` seen outside ISSUE is ignored.
- Reset mid-run: outputs and state return to reset values on the next edge. MAC internal state is not cleared by this block; the integration drives the MAC's reset from the same `rst`.

## Timing
- Let L be the number of cycles from the first ISSUE cycle of an element to its `mac_done` cycle (inclusive of both, L counted as the difference in cycle numbers).
- `start` sampled at cycle 0 -> first ISSUE at cycle 1.
- Element n (0..24) enters ISSUE at cycle 1 + n(L+2).
- `mat_c` byte for element n is updated at the edge ending its `mac_done` cycle.
- Last GAP ends at cycle 25(L+2); `done` is high at cycle 25(L+2)+1.
- `busy` is high from cycle 1 through the `done` cycle and low the next cycle. A new `start` is accepted that cycle.
- With L=6 (bench MAC model): elements at cycles 1, 9, ..., 193; `done` at cycle 201.

## Configuration
- Macro: `MATSEQ_TIMEOUT_EN`.
- **Defined:**
  - a 4-bit wait counter resets on ISSUE entry and increments each ISSUE cycle without `mac_done`;
  - at count == `MAC_TIMEOUT` without `mac_done`: set `err`=1, drop `mac_en`, leave C[i][j] as 0, go to FINISH (`done` pulses);
  - `err` stays 1 until the next accepted `start` or `rst`.
- **Not defined:** no counter; ISSUE waits indefinitely; `err` is tied to 0.

## Test plan
- A = identity (diagonal 0x01, others 0), B[r][c] = 5r+c -> `mat_c` == `mat_b`; `ovf`=0; `done` at cycle 201 with L=6.
- A all 0x02, B all 0x03 -> every C byte 0x1E; `ovf`=0; `mac_a` = 0x0202020202 at every ISSUE.
- A all 0xFF (-1), B all 0x04 -> every C byte 0xEC (-20); check `mac_b` column ordering using B[k][j] = k.
- MAC model raises `mac_overflow` on element (2,3) only -> `ovf`=1 from that element's `mac_done` edge to end of run; next `start` clears it to 0.
- `start` pulsed at cycle 50 and `mat_a` changed mid-run -> ignored; result matches the original A. Then `rst` at cycle 100 -> next cycle all outputs 0, IDLE; a fresh `start` completes correctly.
- `MATSEQ_TIMEOUT_EN` defined, MAC model never asserts `mac_done` -> ISSUE cycles 1..15, `err`=1, `done` pulse at cycle 17, `mat_c`=0.
